// File: rtl/act_unit_pipe_if.sv
// Stream bundle for act_unit_pipe: accumulator-side input beat and writeback-side output beat.
// master drives the beat and out_ready; slave is the activation unit.
interface act_unit_pipe_if #(
  parameter int N     = 32,
  parameter int LANES = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [LANES*N-1:0] in_x;
  logic [1:0]         in_mode;
  logic [N-1:0]       clip_val;
  logic               out_valid;
  logic               out_ready;
  logic [LANES*N-1:0] out_val;

  modport master (
    output in_valid, in_x, in_mode, clip_val, out_ready,
    input  in_ready, out_valid, out_val
  );

  modport slave (
    input  in_valid, in_x, in_mode, clip_val, out_ready,
    output in_ready, out_valid, out_val
  );
endinterface

// File: rtl/act_unit_pipe.sv
// Two-stage, multi-lane fixed-point activation unit (pass / ReLU / leaky ReLU / clipped ReLU)
// with valid/ready on both sides and a saturating count of negative input lanes.
module act_unit_pipe #(
  parameter int N          = 32,
  parameter int Q          = 15,
  parameter int LANES      = 4,
  parameter int LEAK_SHIFT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  act_unit_pipe_if.slave   bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] neg_count
);

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_RELU  = 2'b01,
    MODE_LEAKY = 2'b10,
    MODE_CLIP  = 2'b11
  } mode_e;

  localparam int PW = $clog2(LANES + 1);

  if (LEAK_SHIFT < 1 || LEAK_SHIFT > N - 1 || Q < 0 || Q > N - 1) begin : g_param_check
    $error("act_unit_pipe: LEAK_SHIFT must be 1..N-1 and Q must be 0..N-1");
  end

  logic               in_fire;
  logic               s2_load;

  logic [N-1:0]       lane_x   [LANES];
  logic [N-1:0]       lane_shr [LANES];
  logic [LANES-1:0]   lane_gt;
  logic [PW-1:0]      neg_pop;
  logic [CNT_W:0]     cnt_sum;

  logic               s1_valid;
  mode_e              s1_mode;
  logic [N-1:0]       s1_clip;
  logic [LANES-1:0]   s1_sign;
  logic [LANES-1:0]   s1_gt;
  logic [N-1:0]       s1_x   [LANES];
  logic [N-1:0]       s1_shr [LANES];

  logic               s2_valid;
  logic [LANES*N-1:0] s2_val;
  logic [LANES*N-1:0] s2_next;

  // S1 may refill in the same cycle it hands its beat to S2.
  assign s2_load      = !s2_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_load;
  assign in_fire      = bus.in_valid && bus.in_ready;

  always_comb begin
    neg_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_x[i]   = bus.in_x[i*N +: N];
      lane_shr[i] = $signed(lane_x[i]) >>> LEAK_SHIFT;
      lane_gt[i]  = $signed(lane_x[i]) > $signed(bus.clip_val);
      neg_pop     = neg_pop + PW'(lane_x[i][N-1]);
    end
    cnt_sum = {1'b0, neg_count} + (CNT_W+1)'(neg_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= MODE_PASS;
      s1_clip  <= '0;
      s1_sign  <= '0;
      s1_gt    <= '0;
      for (int i = 0; i < LANES; i++) begin
        s1_x[i]   <= '0;
        s1_shr[i] <= '0;
      end
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_mode  <= mode_e'(bus.in_mode);
      s1_clip  <= bus.clip_val;
      s1_gt    <= lane_gt;
      for (int i = 0; i < LANES; i++) begin
        s1_sign[i] <= lane_x[i][N-1];
        s1_x[i]    <= lane_x[i];
        s1_shr[i]  <= lane_shr[i];
      end
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_comb begin
    s2_next = '0;
    for (int i = 0; i < LANES; i++) begin
      case (s1_mode)
        MODE_PASS:  s2_next[i*N +: N] = s1_x[i];
        MODE_RELU:  s2_next[i*N +: N] = s1_sign[i] ? '0 : s1_x[i];
        MODE_LEAKY: s2_next[i*N +: N] = s1_sign[i] ? s1_shr[i] : s1_x[i];
        MODE_CLIP:  s2_next[i*N +: N] = s1_sign[i] ? '0 : (s1_gt[i] ? s1_clip : s1_x[i]);
        default:    s2_next[i*N +: N] = s1_x[i];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_val   <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_val <= s2_next;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_val   = s2_val;

  // Clear wins over a coincident beat; the sum carries one extra bit to detect saturation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_count <= '0;
    end else if (cnt_clr) begin
      neg_count <= '0;
    end else if (in_fire) begin
      neg_count <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_act_unit_pipe.sv
// Directed bench for act_unit_pipe: single-beat modes, stalled back-to-back stream,
// counter saturation/clear on a CNT_W=4 instance, and reset with beats in flight.
module tb_act_unit_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        cnt_clr;
  logic        cnt_clr4;
  logic [15:0] neg_count;
  logic [3:0]  neg_count4;

  int tests_run    = 0;
  int tests_failed = 0;

  act_unit_pipe_if #(.N(32), .LANES(4)) bus ();
  act_unit_pipe_if #(.N(32), .LANES(4)) bus4 ();

  act_unit_pipe #(.N(32), .Q(15), .LANES(4), .LEAK_SHIFT(3), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cnt_clr   (cnt_clr),
    .neg_count (neg_count)
  );

  act_unit_pipe #(.N(32), .Q(15), .LANES(4), .LEAK_SHIFT(3), .CNT_W(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus4),
    .cnt_clr   (cnt_clr4),
    .neg_count (neg_count4)
  );

  always #5 clk = ~clk;

  // Stream vectors, lanes packed {lane3, lane2, lane1, lane0}; expectations worked by hand.
  localparam logic [127:0] B_X [8] = '{
    {32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFE, 32'h00000001},
    {32'h80000001, 32'h00000000, 32'hFFFFFFFB, 32'h00000005},
    {32'h80000008, 32'h00000040, 32'hFFFFFFF9, 32'hFFFFFFF0},
    {32'hFFFFFFFF, 32'h0000000F, 32'h00000010, 32'h00000011},
    {32'h80000000, 32'h7FFFFFFF, 32'h00000000, 32'h00000001},
    {32'h7FFFFFFF, 32'hFFFFFFF8, 32'hFFFFFFFF, 32'h00000007},
    {32'hC0000000, 32'h00000001, 32'hFFFFFF00, 32'h00000100},
    {32'h00000000, 32'h80000000, 32'h12345678, 32'h7FFFFFFF}
  };
  localparam logic [127:0] B_E [8] = '{
    {32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFE, 32'h00000001},
    {32'h00000000, 32'h00000000, 32'h00000000, 32'h00000005},
    {32'hF0000001, 32'h00000040, 32'hFFFFFFFF, 32'hFFFFFFFE},
    {32'h00000000, 32'h0000000F, 32'h00000010, 32'h00000010},
    {32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000},
    {32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000007},
    {32'h00000000, 32'h00000001, 32'h00000000, 32'h00000100},
    {32'h00000000, 32'h00000000, 32'h12345678, 32'h7FFFFFFF}
  };
  localparam logic [1:0]  B_MODE [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b11};
  localparam logic [31:0] B_CLIP [8] = '{32'h00000001, 32'h0, 32'h0, 32'h00000010,
                                         32'h0, 32'h00000002, 32'h0, 32'h7FFFFFFF};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset out_valid: got %b expected 0", bus.out_valid);
    end
    tests_run++;
    if (bus.out_val !== 128'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset out_val: got %h expected 0", bus.out_val);
    end
    tests_run++;
    if (neg_count !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset neg_count: got %0d expected 0", neg_count);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset in_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  // Drives one beat with out_ready high and checks exact two-cycle latency.
  task automatic test_single(input string name, input logic [1:0] mode, input logic [31:0] clip,
                             input logic [127:0] x, input logic [127:0] exp_val,
                             input logic [15:0] exp_cnt);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_mode   = mode;
    bus.clip_val  = clip;
    bus.in_x      = x;
    tick();
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s early out_valid: got %b expected 0", name, bus.out_valid);
    end
    tests_run++;
    if (neg_count !== exp_cnt) begin
      tests_failed++;
      $display("[TB] FAIL %s neg_count: got %0d expected %0d", name, neg_count, exp_cnt);
    end
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.out_val !== exp_val) begin
      tests_failed++;
      $display("[TB] FAIL %s out: got valid=%b val=%h expected valid=1 val=%h",
               name, bus.out_valid, bus.out_val, exp_val);
    end
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s trailing out_valid: got %b expected 0", name, bus.out_valid);
    end
  endtask

  task automatic test_cnt_clear();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    tests_run++;
    if (neg_count !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL cnt_clr neg_count: got %0d expected 0", neg_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0]  rdy_pat = 16'b0110_1001_1100_0101;
    logic [127:0] prev_val = '0;
    logic         prev_stall = 1'b0;
    logic         exp_ready;
    int           sent = 0;
    int           recv = 0;
    int           cycles = 0;
    while (recv < 8 && cycles < 100) begin
      bus.out_ready = rdy_pat[cycles % 16];
      if (sent < 8) begin
        bus.in_valid = 1'b1;
        bus.in_x     = B_X[sent];
        bus.in_mode  = B_MODE[sent];
        bus.clip_val = B_CLIP[sent];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      exp_ready = !((sent - recv) == 2 && !bus.out_ready);
      tests_run++;
      if (bus.in_ready !== exp_ready) begin
        tests_failed++;
        $display("[TB] FAIL b2b in_ready cycle %0d: got %b expected %b", cycles, bus.in_ready, exp_ready);
      end
      if (prev_stall) begin
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_val !== prev_val) begin
          tests_failed++;
          $display("[TB] FAIL b2b stall hold cycle %0d: got valid=%b val=%h expected valid=1 val=%h",
                   cycles, bus.out_valid, bus.out_val, prev_val);
        end
      end
      tests_run++;
      if (bus.out_valid === 1'b1 && sent == recv) begin
        tests_failed++;
        $display("[TB] FAIL b2b spurious out_valid cycle %0d: got 1 expected 0", cycles);
      end
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        tests_run++;
        if (bus.out_val !== B_E[recv]) begin
          tests_failed++;
          $display("[TB] FAIL b2b beat %0d: got %h expected %h", recv, bus.out_val, B_E[recv]);
        end
        recv++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_val   = bus.out_val;
      if (bus.in_valid && bus.in_ready) sent++;
      @(posedge clk);
      #1;
      cycles++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tests_run++;
    if (recv != 8) begin
      tests_failed++;
      $display("[TB] FAIL b2b timeout: got %0d beats expected 8", recv);
    end
    tests_run++;
    if (neg_count !== 16'd14) begin
      tests_failed++;
      $display("[TB] FAIL b2b neg_count: got %0d expected 14", neg_count);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] exp_cnt;
    bus4.out_ready = 1'b1;
    bus4.in_mode   = 2'b01;
    bus4.clip_val  = '0;
    bus4.in_x      = {4{32'hFFFFFFFF}};
    bus4.in_valid  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      exp_cnt = (k < 3) ? 4'(4 * (k + 1)) : 4'd15;
      tests_run++;
      if (neg_count4 !== exp_cnt) begin
        tests_failed++;
        $display("[TB] FAIL sat beat %0d neg_count: got %0d expected %0d", k, neg_count4, exp_cnt);
      end
    end
    cnt_clr4 = 1'b1;
    tick();
    cnt_clr4 = 1'b0;
    tests_run++;
    if (neg_count4 !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL sat clear-with-beat neg_count: got %0d expected 0", neg_count4);
    end
    bus4.in_x = {32'h00000001, 32'h80000000, 32'h00000000, 32'hFFFFFFFE};
    tick();
    bus4.in_valid = 1'b0;
    tests_run++;
    if (neg_count4 !== 4'd2) begin
      tests_failed++;
      $display("[TB] FAIL sat after-clear neg_count: got %0d expected 2", neg_count4);
    end
    tick();
    tick();
  endtask

  task automatic test_reset_inflight();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_mode   = 2'b00;
    bus.clip_val  = '0;
    bus.in_x      = {32'h00000003, 32'h00000002, 32'hFFFFFFFF, 32'h00000001};
    tick();
    bus.in_x      = {32'h00000007, 32'h00000006, 32'h00000005, 32'h00000004};
    tick();
    bus.in_valid  = 1'b0;
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL inflight setup: got valid=%b ready=%b expected valid=1 ready=0",
               bus.out_valid, bus.in_ready);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || neg_count !== 16'd0 || bus.out_val !== 128'h0) begin
      tests_failed++;
      $display("[TB] FAIL inflight reset: got valid=%b cnt=%0d val=%h expected 0 0 0",
               bus.out_valid, neg_count, bus.out_val);
    end
    tick();
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++;
      if (bus.out_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL inflight stale cycle %0d: got out_valid=%b expected 0", k, bus.out_valid);
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    cnt_clr        = 1'b0;
    cnt_clr4       = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_x       = '0;
    bus.in_mode    = 2'b00;
    bus.clip_val   = '0;
    bus.out_ready  = 1'b1;
    bus4.in_valid  = 1'b0;
    bus4.in_x      = '0;
    bus4.in_mode   = 2'b00;
    bus4.clip_val  = '0;
    bus4.out_ready = 1'b1;

    test_reset();
    test_single("relu", 2'b01, 32'h0,
                {32'h7FFFFFFF, 32'h00000000, 32'hFFFF8000, 32'h00008000},
                {32'h7FFFFFFF, 32'h00000000, 32'h00000000, 32'h00008000}, 16'd1);
    test_single("leaky", 2'b10, 32'h0,
                {32'h00000010, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFF8},
                {32'h00000010, 32'hF0000000, 32'hFFFFFFFF, 32'hFFFFFFFF}, 16'd4);
    test_single("clip", 2'b11, 32'h00030000,
                {32'hFFFF0000, 32'h00018000, 32'h00030000, 32'h00040000},
                {32'h00000000, 32'h00018000, 32'h00030000, 32'h00030000}, 16'd5);
    test_cnt_clear();
    test_back_to_back();
    test_saturation();
    test_reset_inflight();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
